// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master data-memory arbiter:
// FSM encoding, last-grant encoding and the default lock limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    LOCK1 = 2'd3
  } arb_state_t;

  localparam int LOCK_MAX_DEFAULT = 16;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  // Counter must be able to hold the value LOCK_MAX itself.
  function automatic int lock_cnt_width(input int lock_max);
    int w;
    w = $clog2(lock_max + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_lock_timer.sv
// Counts consecutive locked grants to master 1 and raises force_release
// once LOCK_MAX of them have been given, so master 0 is not starved forever.
module mem_arb_lock_timer
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic force_release
);

  localparam int CNT_W = lock_cnt_width(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_MAX);

  logic [CNT_W-1:0] lock_cnt;

  // Clear wins over increment; the count saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_cnt <= '0;
    end else if (clr) begin
      lock_cnt <= '0;
    end else if (inc && (lock_cnt != CNT_LIMIT)) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  assign force_release = (lock_cnt == CNT_LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared data-memory/MMIO port: round-robin between
// the CPU (m0) and the loader/DMA (m1), with a bounded bus lock for m1.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  arb_state_t state;
  arb_state_t next_state;
  logic       last_gnt;
  logic       locked;
  logic       force_release;
  logic       gnt0;
  logic       gnt1;
  logic       timer_inc;
  logic       timer_clr;
  logic       m0_rd;
  logic       m1_rd;

  assign locked = (state == LOCK1) && m1_req && m1_lock;

  // Grant is combinational so a lone requester is served in the same cycle;
  // reset gates everything off regardless of requests.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (locked) begin
      if (force_release && m0_req) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else if (m0_req && m1_req) begin
      if (last_gnt == LAST_M1) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = m0_req;
      gnt1 = m1_req;
    end
  end

  always_comb begin
    next_state = IDLE;
    if (gnt0) begin
      next_state = OWN0;
    end else if (gnt1) begin
      next_state = m1_lock ? LOCK1 : OWN1;
    end
  end

  // Counter only runs while staying locked; a forced release or any exit resets it.
  assign timer_inc = (next_state == LOCK1);
  assign timer_clr = (next_state != LOCK1) || ((state == LOCK1) && force_release);

  mem_arb_lock_timer #(
    .LOCK_MAX(LOCK_MAX)
  ) u_lock_timer (
    .clk          (clk),
    .reset        (reset),
    .inc          (timer_inc),
    .clr          (timer_clr),
    .force_release(force_release)
  );

  // IDLE keeps last_gnt so round-robin fairness survives idle gaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= LAST_M1;
    end else begin
      state <= next_state;
      if (gnt0) begin
        last_gnt <= LAST_M0;
      end else if (gnt1) begin
        last_gnt <= LAST_M1;
      end
    end
  end

  assign m0_rd = gnt0 & ~m0_we;
  assign m1_rd = gnt1 & ~m1_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_rd;
      m1_rvalid <= m1_rd;
      if (m0_rd) begin
        m0_rdata <= mem_rdata;
      end
      if (m1_rd) begin
        m1_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_read  = ~m0_we;
      mem_write = m0_we;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_read  = ~m1_we;
      mem_write = m1_we;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-scenario tasks check grants and
// bus signals inline, while read data flows through a per-master scoreboard.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  logic        force_en = 1'b0;
  logic [31:0] force_val = '0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  function automatic logic [31:0] model_rdata(input logic [31:0] addr);
    return {addr[15:0] ^ 16'h5A5A, ~addr[15:0]};
  endfunction

  assign mem_rdata = force_en ? force_val : model_rdata(mem_addr);

  always #5 clk = ~clk;

  mem_bus_arbiter #(.LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Scoreboard: every granted read must show rvalid with the right data on the
  // next cycle, and no rvalid may appear without a matching granted read.
  always @(negedge clk) begin
    logic [31:0] d;
    if (mon_en) begin
      if (m0_rvalid !== 1'b0 || exp_q0.size() != 0) begin
        checks++;
        if (exp_q0.size() == 0) begin
          errors++;
          $display("[TB] FAIL m0_rvalid_unexpected: got rvalid=%b, required 0", m0_rvalid);
        end else begin
          d = exp_q0.pop_front();
          if (m0_rvalid !== 1'b1 || m0_rdata !== d) begin
            errors++;
            $display("[TB] FAIL m0_read_data: got rvalid=%b rdata=%h, required rvalid=1 rdata=%h",
                     m0_rvalid, m0_rdata, d);
          end
        end
      end
      if (m1_rvalid !== 1'b0 || exp_q1.size() != 0) begin
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $display("[TB] FAIL m1_rvalid_unexpected: got rvalid=%b, required 0", m1_rvalid);
        end else begin
          d = exp_q1.pop_front();
          if (m1_rvalid !== 1'b1 || m1_rdata !== d) begin
            errors++;
            $display("[TB] FAIL m1_read_data: got rvalid=%b rdata=%h, required rvalid=1 rdata=%h",
                     m1_rvalid, m1_rdata, d);
          end
        end
      end
    end
  end

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic drive_idle();
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 32'h0000_0020, '0);
    drive_m1(1'b1, 1'b1, 1'b1, 32'h4000_0000, 32'h1111_2222);
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b00 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_gnt: got gnt=%b rd=%b wr=%b, required 00/0/0",
               {m1_gnt, m0_gnt}, mem_read, mem_write);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus: got addr=%h wdata=%h, required 0/0", mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_read_regs: got rvalid=%b rdata0=%h rdata1=%h, required 00/0/0",
               {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata);
    end
    @(negedge clk);
    drive_idle();
    #2;
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 32'h0000_0010, '0);
    force_val = 32'hDEAD_BEEF;
    force_en = 1'b1;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_m0_gnt: got %b, required 01", {m1_gnt, m0_gnt});
    end
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0000_0010) begin
      errors++;
      $display("[TB] FAIL single_m0_bus: got rd=%b wr=%b addr=%h, required 1/0/00000010",
               mem_read, mem_write, mem_addr);
    end
    exp_q0.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    force_en = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_m0_rvalid: got rv0=%b rdata=%h rv1=%b, required 1/deadbeef/0",
               m0_rvalid, m0_rdata, m1_rvalid);
    end
    @(negedge clk);
    drive_m1(1'b1, 1'b0, 1'b0, 32'h2000_0040, '0);
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10 || mem_addr !== 32'h2000_0040 || m0_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_m1_gnt: got gnt=%b addr=%h rv0=%b, required 10/20000040/0",
               {m1_gnt, m0_gnt}, mem_addr, m0_rvalid);
    end
    exp_q1.push_back(model_rdata(32'h2000_0040));
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (m0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL m0_rdata_hold: got %h, required deadbeef", m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt;
    logic [31:0] a0;
    logic [31:0] wd1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a0  = 32'h0000_0100 + 32'(c * 4);
      wd1 = 32'hCAFE_0000 + 32'(c);
      drive_m0(1'b1, 1'b0, a0, '0);
      drive_m1(1'b1, 1'b1, 1'b0, 32'h4000_0000, wd1);
      #1;
      exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL rr_gnt[%0d]: got %b, required %b", c, {m1_gnt, m0_gnt}, exp_gnt);
      end
      checks++;
      if (mem_write !== exp_gnt[1] || mem_read !== exp_gnt[0]) begin
        errors++;
        $display("[TB] FAIL rr_rdwr[%0d]: got wr=%b rd=%b, required wr=%b rd=%b",
                 c, mem_write, mem_read, exp_gnt[1], exp_gnt[0]);
      end
      if (exp_gnt[1]) begin
        checks++;
        if (mem_addr !== 32'h4000_0000 || mem_wdata !== wd1) begin
          errors++;
          $display("[TB] FAIL rr_m1_bus[%0d]: got addr=%h wdata=%h, required 40000000/%h",
                   c, mem_addr, mem_wdata, wd1);
        end
      end else begin
        exp_q0.push_back(model_rdata(a0));
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_lock();
    logic [1:0]  exp_gnt;
    logic [31:0] a1;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      a1 = 32'h1000_0000 + 32'(c * 4);
      drive_m0(1'b1, 1'b0, 32'h0000_0800, '0);
      drive_m1(1'b1, 1'b0, 1'b1, a1, '0);
      #1;
      exp_gnt = (c == 0 || c == 17 || c == 34) ? 2'b01 : 2'b10;
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL lock_gnt[%0d]: got %b, required %b", c, {m1_gnt, m0_gnt}, exp_gnt);
      end
      if (exp_gnt[0]) exp_q0.push_back(model_rdata(32'h0000_0800));
      else            exp_q1.push_back(model_rdata(a1));
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_lock_drop();
    logic [1:0] exp_gnt;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      drive_m0(1'b1, 1'b0, 32'h0000_0900, '0);
      drive_m1(1'b1, 1'b0, (c != 4), 32'h1000_0900, '0);
      #1;
      exp_gnt = (c == 0 || c == 4 || c == 21) ? 2'b01 : 2'b10;
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL lockdrop_gnt[%0d]: got %b, required %b", c, {m1_gnt, m0_gnt}, exp_gnt);
      end
      if (exp_gnt[0]) exp_q0.push_back(model_rdata(32'h0000_0900));
      else            exp_q1.push_back(model_rdata(32'h1000_0900));
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid_lock();
    logic [1:0] exp_gnt;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_m0(1'b1, 1'b0, 32'h0000_0300, '0);
      drive_m1(1'b1, 1'b0, 1'b1, 32'h0000_0500, '0);
      #1;
      exp_gnt = (c == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL midlock_gnt[%0d]: got %b, required %b", c, {m1_gnt, m0_gnt}, exp_gnt);
      end
      if (exp_gnt[0]) exp_q0.push_back(model_rdata(32'h0000_0300));
      else            exp_q1.push_back(model_rdata(32'h0000_0500));
    end
    @(negedge clk);
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b1 || mem_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midlock_pre: got gnt1=%b rv1=%b rd=%b, required 1/1/1",
               m1_gnt, m1_rvalid, mem_read);
    end
    #1;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b00 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        {m1_rvalid, m0_rvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midlock_async: got gnt=%b rd=%b wr=%b rv=%b, required 00/0/0/00",
               {m1_gnt, m0_gnt}, mem_read, mem_write, {m1_rvalid, m0_rvalid});
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midlock_rdata_clr: got %h/%h, required 0/0", m0_rdata, m1_rdata);
    end
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midlock_release_tie: got %b, required 01", {m1_gnt, m0_gnt});
    end
    exp_q0.push_back(model_rdata(32'h0000_0300));
    mon_en = 1'b1;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_idle();
    logic [31:0] want0;
    logic [31:0] want1;
    want0 = model_rdata(32'h0000_0600);
    want1 = model_rdata(32'h0000_0700);
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 32'h0000_0600, '0);
    #1;
    exp_q0.push_back(want0);
    @(negedge clk);
    drive_idle();
    drive_m1(1'b1, 1'b0, 1'b0, 32'h0000_0700, '0);
    #1;
    exp_q1.push_back(want1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b00 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
        errors++;
        $display("[TB] FAIL idle_bus[%0d]: got gnt=%b rd=%b wr=%b addr=%h wdata=%h, required all 0",
                 k, {m1_gnt, m0_gnt}, mem_read, mem_write, mem_addr, mem_wdata);
      end
      checks++;
      if (m0_rdata !== want0 || m1_rdata !== want1) begin
        errors++;
        $display("[TB] FAIL idle_rdata[%0d]: got %h/%h, required %h/%h",
                 k, m0_rdata, m1_rdata, want0, want1);
      end
      if (k > 0) begin
        checks++;
        if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL idle_rvalid[%0d]: got %b, required 00", k, {m1_rvalid, m0_rvalid});
        end
      end
    end
    @(negedge clk);
    drive_m0(1'b1, 1'b1, 32'h0000_0A00, 32'h0000_00AA);
    drive_m1(1'b1, 1'b1, 1'b0, 32'h4000_0A00, 32'h0000_00BB);
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || mem_write !== 1'b1 || mem_wdata !== 32'h0000_00AA) begin
      errors++;
      $display("[TB] FAIL idle_rr_keep_m1: got gnt=%b wr=%b wdata=%h, required 01/1/000000aa",
               {m1_gnt, m0_gnt}, mem_write, mem_wdata);
    end
    repeat (2) begin
      @(negedge clk);
      drive_idle();
    end
    @(negedge clk);
    drive_m0(1'b1, 1'b1, 32'h0000_0A00, 32'h0000_00AA);
    drive_m1(1'b1, 1'b1, 1'b0, 32'h4000_0A00, 32'h0000_00BB);
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10 || mem_addr !== 32'h4000_0A00) begin
      errors++;
      $display("[TB] FAIL idle_rr_keep_m0: got gnt=%b addr=%h, required 10/40000a00",
               {m1_gnt, m0_gnt}, mem_addr);
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by time limit, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_reset_mid_lock();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
